btb_assoc: RTL and testbench
============================

Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer for the pipelined core's fetch-stage branch predictor. It returns a combinational hit/taken/target prediction for the fetch PC. It is trained from the execute-stage branch resolution port. Over the earlier direct-mapped target cache it adds configurable sets and ways, reset and flush of valid state, per-entry 2-bit saturating direction counters, and pseudo-LRU replacement.

Parameters:
PC_W, 32, PC and target width in bits; bits [1:0] are always zero and are not stored.
SETS, 256, number of sets; power of 2, at least 2; IDX_W = log2(SETS).
WAYS, 2, associativity; legal values are 1, 2 and 4.
TAG_W, PC_W-IDX_W-2, tag width (derived, not overridable).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
lk_pc  in  PC_W  fetch PC to look up.
lk_hit  out  1  a valid entry in set lk_pc[IDX_W+1:2] matches the tag lk_pc[PC_W-1:IDX_W+2].
lk_taken  out  1  lk_hit AND the MSB of the hit entry's counter.
lk_target  out  PC_W  {stored target[PC_W-1:2], 2'b00} of the hit way; all zeros on a miss.
upd_en  in  1  branch-resolution update strobe.
upd_pc  in  PC_W  PC of the resolved branch.
upd_taken  in  1  resolved direction.
upd_target  in  PC_W  resolved target; bits [1:0] are ignored.
flush  in  1  invalidate all entries (context switch / fence.i).

Behaviour:
- Index and tag: index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. The same split applies to lk_pc and upd_pc.
- Storage per way per set: tag, target[PC_W-3:0], valid, ctr[1:0]. Each set also holds WAYS-1 PLRU tree bits; there are none when WAYS=1.
- Reset and flush clear only the valid and PLRU bits. Tag, target and ctr arrays carry no reset.
- Reset: on rst assertion, all valid bits go to 0 and all PLRU bits go to 0 immediately (async). Outputs settle to lk_hit=0, lk_taken=0, lk_target=0. No updates are accepted while rst=1.
- Lookup is purely combinational from current state, with zero-cycle latency. If several ways match, which only happens through corruption, the lowest way index wins.
- Updates are written on the clock edge and are visible to lookups from the next cycle. A same-cycle lookup to the set being updated sees the old contents.
- Update hit (valid entry with matching tag in the upd set):
  - ctr saturating-increments if upd_taken, saturating-decrements otherwise (range 0..3).
  - If upd_taken, target is overwritten with upd_target.
  - PLRU is touched for that way.
- Update miss with upd_taken=1: allocate a victim way.
  - The victim is the lowest-index invalid way; if every way is valid, the victim is the PLRU way.
  - The victim is written with tag, target, valid=1, ctr=2'b10 (weakly taken), and PLRU is touched for it.
- Update miss with upd_taken=0: no state change.
- PLRU encoding:
  - WAYS=2: one bit per set, pointing to the victim way. Touching way w sets it to ~w.
  - WAYS=4: tree bits b0 (root), b1 (ways 0/1), b2 (ways 2/3). Victim = b0 ? (b2 ? 3 : 2) : (b1 ? 1 : 0). Touching way w sets every node on its path to point away from w.
  - WAYS=1: the victim is always way 0.
- Flush: one-cycle synchronous clear of all valid and PLRU bits. Priority is rst > flush > upd_en; an update coincident with flush is dropped.
- Lookups do not modify any state, including PLRU.

Test Plan:
- Reset, then lk_pc=0x0000_0100 -> lk_hit=0, lk_taken=0, lk_target=0x0.
- upd pc=0x100, taken=1, target=0x0000_0200; next cycle lk_pc=0x100 -> hit=1, taken=1, target=0x200. During the update cycle itself -> hit=0.
- Two further updates of pc=0x100 with taken=0 -> ctr 2->1->0, so lk_hit=1, lk_taken=0. A third not-taken update leaves ctr at 0. One taken update -> ctr=1, taken still 0.
- Conflict set, index 0x40 (defaults):
  - Allocate 0x100, then 0x500 (both taken).
  - Update 0x100 taken (a hit, touching way 0).
  - Allocate 0x900, which evicts 0x500.
  - Then lookup 0x500 -> miss; 0x100 -> hit; 0x900 -> hit, target as written.
- With several entries valid, pulse flush with a coincident upd_en for pc=0x300 -> next cycle all lookups miss, including 0x300.
- Assert rst asynchronously mid-cycle after training -> lk_hit drops to 0 before the next clock edge. After release, the first update of a previously trained PC allocates fresh with ctr=2.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters and tree PLRU.
// Lookup is combinational from current state; training and flush take effect at the clock edge.
module btb_assoc #(
    parameter int unsigned PC_W = 32,
    parameter int unsigned SETS = 256,
    parameter int unsigned WAYS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lk_pc,
    output logic            lk_hit,
    output logic            lk_taken,
    output logic [PC_W-1:0] lk_target,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = PC_W - IDX_W - 2;
    localparam int unsigned TGT_W  = PC_W - 2;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    logic [TAG_W-1:0]            tag_q [SETS][WAYS];
    logic [TGT_W-1:0]            tgt_q [SETS][WAYS];
    logic [1:0]                  ctr_q [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]   valid_q, valid_d;
    logic [SETS-1:0][PLRU_W-1:0] plru_q, plru_d;

    logic [IDX_W-1:0]  lk_idx, upd_idx;
    logic [TAG_W-1:0]  lk_tag, upd_tag;
    logic              upd_hit, inv_any, wr_en;
    logic [WAY_W-1:0]  hit_way, inv_way, plru_vict, wr_way;
    logic [1:0]        ctr_cur, ctr_new;
    logic [PLRU_W-1:0] plru_touch;
    logic              unused_pc_bits;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Lookup: descending scan so the lowest matching way wins.
    always_comb begin
        lk_hit    = 1'b0;
        lk_taken  = 1'b0;
        lk_target = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit    = 1'b1;
                lk_taken  = ctr_q[lk_idx][w][1];
                lk_target = {tgt_q[lk_idx][w], 2'b00};
            end
        end
    end

    // Update-side way selection and counter next value.
    always_comb begin
        upd_hit = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
                upd_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[upd_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        wr_way  = upd_hit ? hit_way : (inv_any ? inv_way : plru_vict);
        ctr_cur = ctr_q[upd_idx][hit_way];
        if (!upd_hit) begin
            ctr_new = 2'b10;
        end else if (upd_taken) begin
            ctr_new = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'b01;
        end else begin
            ctr_new = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'b01;
        end
        wr_en = upd_en && !flush && !rst && (upd_hit || upd_taken);
    end

    generate
        if (WAYS == 4) begin : g_plru4
            logic [2:0] p;
            assign p         = plru_q[upd_idx];
            assign plru_vict = p[0] ? (p[2] ? 2'd3 : 2'd2) : (p[1] ? 2'd1 : 2'd0);
            always_comb begin
                plru_touch    = p;
                plru_touch[0] = ~wr_way[1];
                if (wr_way[1]) begin
                    plru_touch[2] = ~wr_way[0];
                end else begin
                    plru_touch[1] = ~wr_way[0];
                end
            end
        end else if (WAYS == 2) begin : g_plru2
            assign plru_vict  = plru_q[upd_idx];
            assign plru_touch = ~wr_way;
        end else begin : g_plru1
            logic unused_plru;
            assign unused_plru = ^{plru_q[upd_idx], wr_way};
            assign plru_vict   = 1'b0;
            assign plru_touch  = 1'b0;
        end
    endgenerate

    // Flush wins over a coincident update.
    always_comb begin
        valid_d = valid_q;
        plru_d  = plru_q;
        if (flush) begin
            valid_d = '0;
            plru_d  = '0;
        end else if (wr_en) begin
            valid_d[upd_idx][wr_way] = 1'b1;
            plru_d[upd_idx]          = plru_touch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            plru_q  <= '0;
        end else begin
            valid_q <= valid_d;
            plru_q  <= plru_d;
        end
    end

    // Payload arrays carry no reset; valid gates their visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[upd_idx][wr_way] <= upd_tag;
            ctr_q[upd_idx][wr_way] <= ctr_new;
            if (upd_taken) begin
                tgt_q[upd_idx][wr_way] <= upd_target[PC_W-1:2];
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed and randomized checks of btb_assoc against a per-set LRU list model.
module tb_btb_assoc;
    localparam int unsigned PC_W = 32;
    localparam int unsigned SETS = 256;
    localparam int unsigned WAYS = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] lk_pc;
    logic            lk_hit;
    logic            lk_taken;
    logic [PC_W-1:0] lk_target;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            flush;

    int n_cmp = 0;
    int n_bad = 0;

    btb_assoc #(.PC_W(PC_W), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
        .lk_target(lk_target), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush)
    );

    always #5 clk = ~clk;

    // Each set is a most-recently-used-first list; with two ways the PLRU bit is exact LRU.
    typedef struct {
        logic [31:0] tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;
    ent_t mq [SETS][$];

    task automatic model_clear();
        for (int s = 0; s < int'(SETS); s++) mq[s].delete();
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic hit, output logic tk,
                                output logic [31:0] tgt);
        int unsigned s;
        logic [31:0] t;
        s   = (pc >> 2) % SETS;
        t   = pc >> 10;
        hit = 1'b0;
        tk  = 1'b0;
        tgt = 32'h0;
        for (int i = 0; i < mq[s].size(); i++) begin
            if (mq[s][i].tag == t) begin
                hit = 1'b1;
                tk  = (mq[s][i].ctr >= 2);
                tgt = mq[s][i].tgt;
            end
        end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        int unsigned s;
        logic [31:0] t;
        int          found;
        ent_t        e;
        s     = (pc >> 2) % SETS;
        t     = pc >> 10;
        found = -1;
        for (int i = 0; i < mq[s].size(); i++) if (mq[s][i].tag == t) found = i;
        if (found >= 0) begin
            e = mq[s][found];
            mq[s].delete(found);
            if (tk) begin
                e.ctr = (e.ctr == 3) ? 3 : e.ctr + 1;
                e.tgt = tg & 32'hFFFF_FFFC;
            end else begin
                e.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
            end
            mq[s].push_front(e);
        end else if (tk) begin
            if (mq[s].size() == int'(WAYS)) void'(mq[s].pop_back());
            e.tag = t;
            e.tgt = tg & 32'hFFFF_FFFC;
            e.ctr = 2;
            mq[s].push_front(e);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // One cycle: drive, compare lookup against the pre-edge model, clock, advance model.
    task automatic step(input logic [31:0] lpc, input logic ue, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg, input logic fl, input string nm);
        logic        h, t;
        logic [31:0] g;
        lk_pc      = lpc;
        upd_en     = ue;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        flush      = fl;
        #4;
        model_lookup(lpc, h, t, g);
        chk({nm, "_hit"}, 32'(lk_hit), 32'(h));
        chk({nm, "_taken"}, 32'(lk_taken), 32'(t));
        chk({nm, "_target"}, lk_target, g);
        @(posedge clk);
        if (fl) model_clear();
        else if (ue) model_update(upc, ut, utg);
        #1;
        upd_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic expect_lk(input logic [31:0] lpc, input logic h, input logic t,
                             input logic [31:0] g, input string nm);
        lk_pc  = lpc;
        upd_en = 1'b0;
        flush  = 1'b0;
        #4;
        chk({nm, "_hit"}, 32'(lk_hit), 32'(h));
        chk({nm, "_taken"}, 32'(lk_taken), 32'(t));
        chk({nm, "_target"}, lk_target, g);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] idx_pool [3];
        logic [31:0] pc, lpc, tg;
        idx_pool[0] = 32'h40;
        idx_pool[1] = 32'h41;
        idx_pool[2] = 32'h02;

        rst = 1'b1; lk_pc = '0; upd_en = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        expect_lk(32'h100, 1'b0, 1'b0, 32'h0, "reset");
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, "alloc_same_cycle");
        expect_lk(32'h100, 1'b1, 1'b1, 32'h200, "alloc_next");
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, "nt1");
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, "nt2");
        expect_lk(32'h100, 1'b1, 1'b0, 32'h200, "ctr0");
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, "nt3");
        expect_lk(32'h100, 1'b1, 1'b0, 32'h200, "ctr0_sat");
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, "t_from0");
        expect_lk(32'h100, 1'b1, 1'b0, 32'h200, "ctr1");

        // Conflict set index 0x40.
        step(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "pre_conf_flush");
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h1000, 1'b0, "conf_a100");
        step(32'h500, 1'b1, 32'h500, 1'b1, 32'h1500, 1'b0, "conf_a500");
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h1000, 1'b0, "conf_h100");
        step(32'h900, 1'b1, 32'h900, 1'b1, 32'h1900, 1'b0, "conf_a900");
        expect_lk(32'h500, 1'b0, 1'b0, 32'h0, "conf_500_evicted");
        expect_lk(32'h100, 1'b1, 1'b1, 32'h1000, "conf_100_kept");
        expect_lk(32'h900, 1'b1, 1'b1, 32'h1900, "conf_900_new");

        step(32'h100, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1, "flush_upd");
        expect_lk(32'h100, 1'b0, 1'b0, 32'h0, "flush_100");
        expect_lk(32'h900, 1'b0, 1'b0, 32'h0, "flush_900");
        expect_lk(32'h300, 1'b0, 1'b0, 32'h0, "flush_300_dropped");

        for (int n = 0; n < 500; n++) begin
            pc  = ($urandom_range(0, 4) << 10) | (idx_pool[$urandom_range(0, 2)] << 2)
                | $urandom_range(0, 3);
            lpc = ($urandom_range(0, 4) << 10) | (idx_pool[$urandom_range(0, 2)] << 2)
                | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) lpc = pc;
            tg  = $urandom;
            step(lpc, 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), tg,
                 ($urandom_range(0, 49) == 0), "rand");
        end

        // Asynchronous reset mid-cycle.
        step(32'hA0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0, "tr1");
        step(32'hA0, 1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0, "tr2");
        expect_lk(32'hA0, 1'b1, 1'b1, 32'hB0, "pre_rst");
        lk_pc = 32'hA0;
        #4;
        rst = 1'b1;
        #1;
        chk("async_rst_hit", 32'(lk_hit), 32'h0);
        chk("async_rst_target", lk_target, 32'h0);
        model_clear();
        @(posedge clk);
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(32'hA0, 1'b1, 32'hA0, 1'b1, 32'hC0, 1'b0, "post_rst_alloc");
        expect_lk(32'hA0, 1'b1, 1'b1, 32'hC0, "post_rst_ctr2");
        step(32'hA0, 1'b1, 32'hA0, 1'b0, 32'h0, 1'b0, "post_rst_nt");
        expect_lk(32'hA0, 1'b1, 1'b0, 32'hC0, "post_rst_ctr1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
